// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared types and default sizing for main_memory_responder.
// The buffer entry struct is sized from the defaults below; the top-level
// DATA_WIDTH and MEM_WORDS parameters are expected to keep those values.
package mem_resp_pkg;

  localparam int DATA_W           = 32;
  localparam int MEM_WORDS_DEF    = 4096;
  localparam int IDX_W            = $clog2(MEM_WORDS_DEF);
  localparam int WB_DEPTH_DEF     = 4;
  localparam int PTR_W            = $clog2(WB_DEPTH_DEF);
  localparam int READ_LATENCY_DEF = 4;
  localparam int CNT_W            = $clog2(READ_LATENCY_DEF) + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_WAIT = 2'd1,
    RESP      = 2'd2
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/write_buffer_fifo.sv
// write_buffer_fifo: circular eviction buffer. The head entry is offered for
// draining every cycle the buffer holds data. With WB_FORWARD_EN defined a
// combinational lookup returns the youngest entry matching lookup_idx.
module write_buffer_fifo
  import mem_resp_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [IDX_W-1:0]       push_idx,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   pop,
  output logic [IDX_W-1:0]       head_idx,
  output logic [DATA_W-1:0]      head_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  input  logic [IDX_W-1:0]       lookup_idx,
  output logic                   hit,
  output logic [DATA_W-1:0]      hit_data
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t       slots [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty     = (count == '0);
  assign full      = (count == (PW+1)'(DEPTH));
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_idx  = slots[rd_ptr].idx;
  assign head_data = slots[rd_ptr].data;

  // Pointers wrap naturally at DEPTH; a push and pop together keep the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= '{idx: push_idx, data: push_data};
  end

`ifdef WB_FORWARD_EN
  // Scan oldest to youngest so the last match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (((PW+1)'(k) < count) && (slots[rd_ptr + PW'(k)].idx == lookup_idx)) begin
        hit      = 1'b1;
        hit_data = slots[rd_ptr + PW'(k)].data;
      end
    end
  end
`else
  logic unused_lookup;
  assign unused_lookup = ^lookup_idx;
  assign hit           = 1'b0;
  assign hit_data      = '0;
`endif

endmodule

// File: rtl/main_memory_responder.sv
// main_memory_responder: RAM-side responder for the two-way cache. Fills
// return after READ_LATENCY cycles; evictions go through a write buffer that
// drains one word per cycle into the backing array.
// Optional macro WB_FORWARD_EN: when defined, fills are forwarded from the
// write buffer; when undefined, a fill waits until the buffer is empty.
// Handshake: stall is combinational and means "hold every cache input this
// cycle"; rd_valid is a one-cycle strobe with rd_from_ram valid alongside it.
module main_memory_responder
  import mem_resp_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_W,
  parameter int RAM_ADDR_WIDTH = 32,
  parameter int MEM_WORDS      = MEM_WORDS_DEF,
  parameter int READ_LATENCY   = READ_LATENCY_DEF,
  parameter int WB_DEPTH       = WB_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      re_from_ram,
  input  logic [RAM_ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0]     rd_from_ram,
  output logic                      rd_valid,
  input  logic                      we_to_ram,
  input  logic [DATA_WIDTH-1:0]     wd_to_ram,
  input  logic [RAM_ADDR_WIDTH-1:0] w_addr_to_ram,
  output logic                      stall
);

  localparam int CW  = $clog2(READ_LATENCY) + 1;
  localparam int WCW = $clog2(WB_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [IDX_W-1:0]      rd_idx;
  logic [IDX_W-1:0]      req_idx;
  logic [IDX_W-1:0]      w_idx;
  logic [IDX_W-1:0]      lookup_idx;
  logic [DATA_WIDTH-1:0] fill_data;
  logic                  resp_ok;

  logic                  push;
  logic                  pop;
  logic                  wb_empty;
  logic                  wb_full;
  logic [WCW-1:0]        wb_count;
  logic [IDX_W-1:0]      head_idx;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;

  // Word index ignores the byte offset and aliases the upper address bits.
  assign req_idx    = addr[IDX_W+1:2];
  assign w_idx      = w_addr_to_ram[IDX_W+1:2];
  assign lookup_idx = (state == IDLE) ? req_idx : rd_idx;
  assign push       = we_to_ram && !wb_full;
  assign pop        = !wb_empty;

  assign stall = !rst && ((state == IDLE && re_from_ram) ||
                          (state == READ_WAIT) ||
                          (we_to_ram && wb_full));

  write_buffer_fifo #(.DEPTH(WB_DEPTH)) u_wb (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_idx   (w_idx),
    .push_data  (wd_to_ram),
    .pop        (pop),
    .head_idx   (head_idx),
    .head_data  (head_data),
    .empty      (wb_empty),
    .full       (wb_full),
    .count      (wb_count),
    .lookup_idx (lookup_idx),
    .hit        (fwd_hit),
    .hit_data   (fwd_data)
  );

  // Drain the buffer head into the array; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (pop) mem[head_idx] <= head_data;
  end

  // Fill data source: array with write-first for the draining head, then
  // (when forwarding) the youngest buffered match, then a same-cycle eviction.
  always_comb begin
    fill_data = mem[lookup_idx];
    if (pop && head_idx == lookup_idx) fill_data = head_data;
`ifdef WB_FORWARD_EN
    if (fwd_hit) fill_data = fwd_data;
    if (state == IDLE && push && w_idx == lookup_idx) fill_data = wd_to_ram;
`endif
  end

`ifdef WB_FORWARD_EN
  assign resp_ok = 1'b1;
  logic unused_bits;
  assign unused_bits = ^{addr[RAM_ADDR_WIDTH-1:IDX_W+2], addr[1:0],
                         w_addr_to_ram[RAM_ADDR_WIDTH-1:IDX_W+2], w_addr_to_ram[1:0],
                         wb_count};
`else
  // Without forwarding the response waits for an empty buffer, and a
  // same-cycle eviction in IDLE must land in the array first.
  assign resp_ok = wb_empty && !(state == IDLE && push);
  logic unused_bits;
  assign unused_bits = ^{addr[RAM_ADDR_WIDTH-1:IDX_W+2], addr[1:0],
                         w_addr_to_ram[RAM_ADDR_WIDTH-1:IDX_W+2], w_addr_to_ram[1:0],
                         wb_count, fwd_hit, fwd_data};
`endif

  // Fill FSM: count the latency, capture fill data on entry to RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rd_idx      <= '0;
      rd_valid    <= 1'b0;
      rd_from_ram <= '0;
    end else begin
      rd_valid    <= 1'b0;
      rd_from_ram <= '0;
      case (state)
        IDLE: begin
          if (re_from_ram) begin
            rd_idx <= req_idx;
            cnt    <= CW'(READ_LATENCY - 1);
            if (READ_LATENCY == 1 && resp_ok) begin
              state       <= RESP;
              rd_valid    <= 1'b1;
              rd_from_ram <= fill_data;
            end else begin
              state <= READ_WAIT;
            end
          end
        end
        READ_WAIT: begin
          if (cnt > CW'(1)) begin
            cnt <= cnt - CW'(1);
          end else begin
            cnt <= '0;
            if (resp_ok) begin
              state       <= RESP;
              rd_valid    <= 1'b1;
              rd_from_ram <= fill_data;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_main_memory_responder.sv
// tb_main_memory_responder: directed table, hand sequences and random traffic
// for main_memory_responder, checked against a cycle-level reference model.
module tb_main_memory_responder;
  import mem_resp_pkg::*;

  localparam int RL    = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        re_from_ram;
  logic [31:0] addr;
  logic [31:0] rd_from_ram;
  logic        rd_valid;
  logic        we_to_ram;
  logic [31:0] wd_to_ram;
  logic [31:0] w_addr_to_ram;
  logic        stall;

  always #5 clk = ~clk;

  main_memory_responder dut (
    .clk           (clk),
    .rst           (rst),
    .re_from_ram   (re_from_ram),
    .addr          (addr),
    .rd_from_ram   (rd_from_ram),
    .rd_valid      (rd_valid),
    .we_to_ram     (we_to_ram),
    .wd_to_ram     (wd_to_ram),
    .w_addr_to_ram (w_addr_to_ram),
    .stall         (stall)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: value last written per word index, buffer occupancy,
  // and the outstanding fill (request cycle, index, scheduled response cycle).
  logic [31:0]      ref_mem [int];
  logic [DATA_W-1:0] exp_q[$];
  int               cyc = 0;
  int               occ = 0;
  bit               busy = 0;
  int               req_cyc = 0;
  int               resp_cyc = -1;
  logic [IDX_W-1:0] req_idx = '0;

  typedef struct {
    logic        re;
    logic [31:0] ra;
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        exp_stall;
    logic        exp_valid;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit resp_allowed(input int o, input bit same_cycle_write);
`ifdef WB_FORWARD_EN
    return 1'b1 || (o < 0) || same_cycle_write;
`else
    return (o == 0) && !same_cycle_write;
`endif
  endfunction

  task automatic model_reset();
    occ = 0;
    busy = 0;
    resp_cyc = -1;
    exp_q.delete();
  endtask

  // One clock cycle: drive, predict, sample at negedge, compare, advance model.
  task automatic tick(input logic re, input logic [31:0] ra, input logic we,
                      input logic [31:0] wa, input logic [31:0] wd,
                      output logic got_valid, output logic [31:0] got_data,
                      output logic got_stall);
    logic [IDX_W-1:0] ai;
    logic [IDX_W-1:0] wi;
    logic             exp_valid;
    logic             exp_stall;
    logic             accept;
    logic [31:0]      val;
    re_from_ram   = re;
    addr          = ra;
    we_to_ram     = we;
    w_addr_to_ram = wa;
    wd_to_ram     = wd;
    ai = ra[IDX_W+1:2];
    wi = wa[IDX_W+1:2];
    exp_valid = (resp_cyc == cyc);
    if (re && !busy && !exp_valid) begin
      busy = 1;
      req_cyc = cyc;
      req_idx = ai;
    end
    accept    = we && (occ < DEPTH);
    exp_stall = busy || (we && occ == DEPTH);
    if (busy && cyc >= req_cyc + RL - 1 && resp_allowed(occ, (cyc == req_cyc) && accept)) begin
      if (cyc == req_cyc && accept && wi == req_idx) val = wd;
      else val = ref_mem[int'(req_idx)];
      exp_q.push_back(val);
      resp_cyc = cyc + 1;
      busy = 0;
    end
    @(negedge clk);
    got_valid = rd_valid;
    got_data  = rd_from_ram;
    got_stall = stall;
    check("stall", 32'(stall), 32'(exp_stall));
    check("rd_valid", 32'(rd_valid), 32'(exp_valid));
    if (exp_valid) begin
      if (exp_q.size() == 0) check("rd_queue", 32'(1), 32'(0));
      else check("rd_data", rd_from_ram, exp_q.pop_front());
    end
    if (accept) ref_mem[int'(wi)] = wd;
    if (occ > 0) occ--;
    if (accept) occ++;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(output logic v, output logic [31:0] d);
    logic s;
    tick(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, v, d, s);
  endtask

  // Idle until a fill completes; lat is counted in cycles from the request.
  task automatic wait_resp(output logic [31:0] data, output int lat);
    logic        v;
    logic [31:0] d;
    data = '0;
    lat  = -1;
    for (int i = 1; i <= 30; i++) begin
      idle(v, d);
      if (v) begin
        data = d;
        lat  = i;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: no rd_valid within 30 cycles (cycle %0d)", cyc);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stall"}, 32'(stall), 32'(0));
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'(0));
    check({tag, "_rd_data"}, rd_from_ram, 32'(0));
    check({tag, "_wb_count"}, 32'(dut.u_wb.count), 32'(0));
    check({tag, "_state"}, 32'(dut.state), 32'(IDLE));
  endtask

  initial begin
    logic        v;
    logic [31:0] d;
    logic        s;
    int          lat;
    int          idx;
    logic        re;
    logic        we;
    logic [31:0] ra;
    logic [31:0] wa;

    vecs[0] = '{1'b1, 32'h14, 1'b0, 32'h0,  32'h0,    1'b1, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h0,  1'b0, 32'h0,  32'h0,    1'b1, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 32'h0,  1'b0, 32'h0,  32'h0,    1'b1, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 32'h0,  1'b0, 32'h0,  32'h0,    1'b1, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 32'h0,  1'b0, 32'h0,  32'h0,    1'b0, 1'b1, 32'hDEADBEEF};
    vecs[5] = '{1'b0, 32'h0,  1'b1, 32'h40, 32'h1234, 1'b0, 1'b0, 32'h0};
    vecs[6] = '{1'b0, 32'h0,  1'b0, 32'h0,  32'h0,    1'b0, 1'b0, 32'h0};
    vecs[7] = '{1'b0, 32'h0,  1'b0, 32'h0,  32'h0,    1'b0, 1'b0, 32'h0};

    // Clock/reset
    rst = 1'b1;
    re_from_ram = 1'b0; addr = '0; we_to_ram = 1'b0; wd_to_ram = '0; w_addr_to_ram = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    model_reset();

    // Preload index 5 through the write path, then reset: the array survives.
    tick(1'b0, 32'h0, 1'b1, 32'h14, 32'hDEADBEEF, v, d, s);
    repeat (4) idle(v, d);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Directed table: read latency after reset, then an eviction drain.
    for (int i = 0; i < 8; i++) begin
      tick(vecs[i].re, vecs[i].ra, vecs[i].we, vecs[i].wa, vecs[i].wd, v, d, s);
      check($sformatf("tbl%0d_stall", i), 32'(s), 32'(vecs[i].exp_stall));
      check($sformatf("tbl%0d_valid", i), 32'(v), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) check($sformatf("tbl%0d_data", i), d, vecs[i].exp_data);
      if (i == 6) check("drain_mem16", dut.mem[16], 32'h1234);
    end

    // Miss with a dirty eviction to the same word; a later write lengthens the
    // wait only when forwarding is disabled.
    tick(1'b1, 32'h80, 1'b1, 32'h80, 32'hAAAA, v, d, s);
    idle(v, d);
    tick(1'b0, 32'h0, 1'b1, 32'h84, 32'hBBBB, v, d, s);
    lat = 2;
    for (int i = 3; i <= 30 && !v; i++) begin
      idle(v, d);
      lat = i;
    end
    check("fwd_data", d, 32'hAAAA);
`ifdef WB_FORWARD_EN
    check("fwd_latency", 32'(lat), 32'(RL));
`else
    check("fwd_latency", 32'(lat), 32'(RL + 1));
`endif
    repeat (3) idle(v, d);

    // Write-after-write to one word, then read it back.
    tick(1'b0, 32'h0, 1'b1, 32'h10, 32'h1, v, d, s);
    tick(1'b0, 32'h0, 1'b1, 32'h10, 32'h2, v, d, s);
    tick(1'b1, 32'h10, 1'b0, 32'h0, 32'h0, v, d, s);
    wait_resp(d, lat);
    check("waw_data", d, 32'h2);
    check("waw_latency", 32'(lat), 32'(RL));
    repeat (3) idle(v, d);
    check("waw_mem4", dut.mem[4], 32'h2);

    // Asynchronous reset while a fill waits and a write is buffered.
    tick(1'b1, 32'h14, 1'b0, 32'h0, 32'h0, v, d, s);
    tick(1'b0, 32'h0, 1'b1, 32'h18, 32'h5555, v, d, s);
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    idle(v, d);
    check("post_rst_no_valid", 32'(v), 32'(0));
    tick(1'b1, 32'h14, 1'b0, 32'h0, 32'h0, v, d, s);
    wait_resp(d, lat);
    check("post_rst_data", d, 32'hDEADBEEF);
    check("post_rst_latency", 32'(lat), 32'(RL));

    // Random traffic over 16 pre-written words with aliased upper address bits.
    for (int i = 0; i < 16; i++)
      tick(1'b0, 32'h0, 1'b1, 32'((32 + i) << 2), $urandom(), v, d, s);
    for (int n = 0; n < 1500; n++) begin
      re  = ($urandom_range(0, 9) < 3);
      we  = ($urandom_range(0, 9) < 4);
      idx = 32 + $urandom_range(0, 15);
      ra  = ($urandom() & 32'hFFFF_C000) | 32'(idx << 2) | ($urandom() & 32'h3);
      idx = 32 + $urandom_range(0, 15);
      wa  = ($urandom() & 32'hFFFF_C000) | 32'(idx << 2) | ($urandom() & 32'h3);
      tick(re, ra, we, wa, $urandom(), v, d, s);
    end
    repeat (20) idle(v, d);
    check("pending_resp", 32'(exp_q.size()), 32'(0));
    check("model_idle", 32'(busy), 32'(0));
    for (int i = 32; i < 48; i++)
      check($sformatf("final_mem%0d", i), dut.mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute bound on run time.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
